// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: register address width, register count, zero register.
// Used by the register file and its busy scoreboard.
package cpu_defs;

    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;
    localparam int DEF_DATA_W = 16;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] a);
        return a == REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_sb_2r1w_scoreboard.sv
// Busy scoreboard: per-register pending bits, reserve/release priority, stall.
// REGFILE_BYPASS_EN lets a matching writeback hide the operand's busy bit.
module regfile_scoreboard
    import cpu_defs::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic                 iss_en,
    input  logic [ADDR_W-1:0]    iss_addr,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy
);

    logic rs_pend;
    logic rt_pend;
    logic wr_live;
    logic iss_live;

    assign wr_live  = wr_en && (wr_addr != '0);
    assign iss_live = iss_en && !stall && (iss_addr != '0);

    always_comb begin
        rs_pend = (rs_addr != '0) && busy[rs_addr];
        rt_pend = (rt_addr != '0) && busy[rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && wr_addr == rs_addr) rs_pend = 1'b0;
        if (wr_live && wr_addr == rt_addr) rt_pend = 1'b0;
`endif
    end

    assign stall = rs_pend || rt_pend;

    // Reserve is applied last so a new producer wins over a same-cycle release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wr_live)  busy[wr_addr]  <= 1'b0;
            if (iss_live) busy[iss_addr] <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb_2r1w.sv
// 32x16 2-read/1-write register file with integrated busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb_2r1w
    import cpu_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 iss_en,
    input  logic [ADDR_W-1:0]    iss_addr,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy
);

    localparam int NENT = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NENT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Entry 0 is never written, so it reads 0 without a special case.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rst_n) begin
            rs_data = regs[rs_addr];
            rt_data = regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && wr_addr != '0 && wr_addr == rs_addr) rs_data = wr_data;
            if (wr_en && wr_addr != '0 && wr_addr == rt_addr) rt_data = wr_data;
`endif
        end
    end

    regfile_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .stall   (stall),
        .busy    (busy)
    );

endmodule
